hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Owns the HI/LO register pair for the MIPS core.
- Sequences the multi-cycle multiply and divide operations issued from the EX stage: mult, multu, div, divu, mul.
- Raises a pipeline stall request while an operation runs.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Sits beside the EX-stage ALU; its stall request feeds the central stall controller.

Parameters:
- WIDTH, 32, operand width. Fixed at 32; iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  EX stage holds a valid instruction this cycle
- hilo_op  in  9  one-hot {mfhi, mflo, mthi, mtlo, mult, multu, div, divu, mul}
- src_a  in  32  rs value (dividend / multiplicand / mthi-mtlo data)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  cancel in-flight operation
- ex_stall  in  1  EX held by another stall source
- stallreq  out  1  hold IF..EX
- done  out  1  result valid this cycle
- mul_result  out  32  low 32 bits of signed product for mul; GPR write data
- hilo_rdata  out  32  HI for mfhi, LO for mflo, else 0
- hi  out  32  current HI
- lo  out  32  current LO

Behaviour:
- Reset: state IDLE, HI=LO=0, counter=0, stallreq=0, done=0, mul_result=0, hilo_rdata=0.
- States:
  - IDLE: no operation in flight.
  - MUL: 32 shift-add iterations on operand magnitudes.
  - DIV: 32 restoring-division iterations on magnitudes.
  - DONE: result held.
- Start condition: IDLE & op_valid & any of mult/multu/div/divu/mul.
  - Start cycle (cycle 0): latch magnitudes and sign flags, counter<=0, go to MUL or DIV.
  - stallreq is asserted combinationally in cycle 0.
- Iterations: cycles 1..32, one iteration per cycle. stallreq=1 throughout.
  - On the edge completing iteration 32, enter DONE.
  - On that same edge, commit HI/LO for mult/multu/div/divu.
  - mul never writes HI/LO.
- Sign rules:
  - Signed ops (mult, div, mul) use absolute values of the operands.
  - Product is negated (64-bit) when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Unsigned ops use the raw operands.
- Result mapping:
  - mult/multu: HI=product[63:32], LO=product[31:0].
  - div/divu: LO=quotient, HI=remainder.
- Divide by zero: still takes the full 33-cycle stall; LO=0xFFFFFFFF, HI=dividend (raw src_a), for both div and divu.
- DONE:
  - done=1, stallreq=0.
  - mul_result is valid; hi/lo show the new values.
  - If ex_stall=1, remain in DONE holding outputs; HI/LO are not rewritten.
  - When ex_stall=0, go to IDLE next edge.
  - The same instruction is never restarted.
- Total stallreq high time: 33 cycles (cycle 0 through iteration 32).
- mthi/mtlo: in IDLE with op_valid, write src_a to HI/LO at the clock edge, single cycle, no stall.
- mfhi/mflo: hilo_rdata is combinational from current HI/LO, no stall. A write committed on an edge is visible to mfhi/mflo in the following cycle.
- op_valid/hilo_op while in MUL/DIV/DONE: ignored; operands are already latched.
- flush:
  - In MUL/DIV/DONE: go to IDLE next edge. No HI/LO write unless the DONE commit already occurred; flush in DONE keeps the committed value. stallreq drops the cycle after flush.
  - Flush in IDLE suppresses a start, mthi and mtlo that cycle.
- rst mid-operation: immediately IDLE and HI=LO=0; no partial result is written.
- Simultaneous flush and rst: rst wins.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> stallreq high exactly 33 cycles, then done=1; HI=0xFFFFFFFE, LO=0x00000001.
- div src_a=-7 (0xFFFFFFF9), src_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- divu 0x1234 / 0 -> 33-cycle stall; LO=0xFFFFFFFF, HI=0x00001234.
- mul -3 x 5 with HI/LO preset via mthi 0xAAAA, mtlo 0x5555 -> mul_result=0xFFFFFFF1; HI/LO unchanged; then mfhi -> hilo_rdata=0x0000AAAA.
- div 100/7 with flush asserted at iteration 10 -> IDLE next cycle, HI/LO unchanged. A new multu 3 x 4 then yields LO=12, HI=0.
- mult 2 x 3 with ex_stall=1 for 4 cycles at DONE -> done stays high 5 cycles, LO=6 written once, then IDLE.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO register pair and multi-cycle multiply/divide sequencer for the MIPS
// EX stage. Runs mult/multu/div/divu/mul as 32 shift-add or restoring-divide iterations on
// operand magnitudes, requesting a pipeline stall while busy, and serves mfhi/mflo/mthi/mtlo.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   op_valid    - EX holds a valid instruction this cycle
//   hilo_op     - one-hot {mfhi, mflo, mthi, mtlo, mult, multu, div, divu, mul}
//   src_a/src_b - rs/rt operand values
//   flush       - cancel in-flight operation (and suppress starts/writes in IDLE)
//   ex_stall    - EX held by another stall source (keeps DONE)
//   stallreq    - hold IF..EX
//   done        - result valid this cycle
//   mul_result  - low word of the signed product for mul
//   hilo_rdata  - HI for mfhi, LO for mflo, else 0
//   hi/lo       - current HI/LO
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [8:0]       hilo_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] mul_result,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}; div: {rem, dividend/quo}
  logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_raw_a;
  logic               r_neg_q;    // negate product / quotient
  logic               r_neg_r;    // negate remainder
  logic               r_div0;
  logic               r_wr_hilo;  // mult/multu/div/divu commit to HI/LO; mul does not
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mul_result;

  logic w_op_mfhi, w_op_mflo, w_op_mthi, w_op_mtlo;
  logic w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_mul;
  assign {w_op_mfhi, w_op_mflo, w_op_mthi, w_op_mtlo,
          w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_mul} = hilo_op;

  logic w_idle_ok, w_start, w_signed, w_a_neg, w_b_neg, w_last;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_idle_ok = (r_state == StIdle) && op_valid && !flush;
  assign w_start   = w_idle_ok && (|hilo_op[4:0]);
  assign w_signed  = w_op_mult || w_op_div || w_op_mul;
  assign w_a_neg   = w_signed && src_a[WIDTH-1];
  assign w_b_neg   = w_signed && src_b[WIDTH-1];
  assign w_abs_a   = w_a_neg ? -src_a : src_a;
  assign w_abs_b   = w_b_neg ? -src_b : src_b;
  assign w_last    = (r_cnt == CntW'(WIDTH - 1));

  // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right (carry included).
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mul_next, w_prod_fin;
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
  assign w_prod_fin = r_neg_q ? -w_mul_next : w_mul_next;

  // Restoring step: trial-subtract the divisor from {rem, next dividend bit}; one extra bit
  // keeps the sign of the trial since the shifted remainder can reach 2^WIDTH.
  logic [WIDTH+1:0]     w_trial;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [WIDTH-1:0]     w_quo_fin, w_rem_fin;
  assign w_trial    = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opb};
  assign w_div_next = w_trial[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_quo_fin  = r_neg_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
  assign w_rem_fin  = r_neg_r ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_opb        <= '0;
      r_raw_a      <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_div0       <= 1'b0;
      r_wr_hilo    <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_mul_result <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_cnt     <= '0;
            r_raw_a   <= src_a;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_div0    <= (src_b == '0);
            r_wr_hilo <= !w_op_mul;
            if (w_op_div || w_op_divu) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_opb   <= w_abs_b;
              r_state <= StDiv;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
              r_opb   <= w_abs_a;
              r_state <= StMul;
            end
          end else if (w_idle_ok) begin
            if (w_op_mthi) r_hi <= src_a;
            if (w_op_mtlo) r_lo <= src_a;
          end
        end
        StMul: begin
          if (flush) begin
            r_state <= StIdle;
          end else begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
              r_state <= StDone;
              if (r_wr_hilo) begin
                r_hi <= w_prod_fin[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_fin[WIDTH-1:0];
              end else begin
                r_mul_result <= w_prod_fin[WIDTH-1:0];
              end
            end
          end
        end
        StDiv: begin
          if (flush) begin
            r_state <= StIdle;
          end else begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
              r_state <= StDone;
              if (r_div0) begin
                r_hi <= r_raw_a;
                r_lo <= '1;
              end else begin
                r_hi <= w_rem_fin;
                r_lo <= w_quo_fin;
              end
            end
          end
        end
        StDone: begin
          if (flush || !ex_stall) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign stallreq   = (r_state == StMul) || (r_state == StDiv) || w_start;
  assign done       = (r_state == StDone);
  assign mul_result = r_mul_result;
  assign hi         = r_hi;
  assign lo         = r_lo;

  always_comb begin
    hilo_rdata = '0;
    if (op_valid && w_op_mfhi)      hilo_rdata = r_hi;
    else if (op_valid && w_op_mflo) hilo_rdata = r_lo;
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;

  localparam logic [8:0] OpMfhi  = 9'h100;
  localparam logic [8:0] OpMflo  = 9'h080;
  localparam logic [8:0] OpMthi  = 9'h040;
  localparam logic [8:0] OpMtlo  = 9'h020;
  localparam logic [8:0] OpMult  = 9'h010;
  localparam logic [8:0] OpMultu = 9'h008;
  localparam logic [8:0] OpDiv   = 9'h004;
  localparam logic [8:0] OpDivu  = 9'h002;
  localparam logic [8:0] OpMul   = 9'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [8:0]  hilo_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        ex_stall = 1'b0;
  logic        stallreq, done;
  logic [31:0] mul_result, hilo_rdata, hi, lo;

  int total = 0;
  int bad = 0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .hilo_op    (hilo_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .stallreq   (stallreq),
    .done       (done),
    .mul_result (mul_result),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues an op and holds it until done; returns at the negedge of the first DONE cycle.
  task automatic run_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stall_n, output bit seen_done);
    step();
    op_valid = 1'b1; hilo_op = op; src_a = a; src_b = b;
    stall_n = 0; seen_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (stallreq) stall_n++;
      step();
    end
    op_valid = 1'b0; hilo_op = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (mul_result !== 32'h0) begin bad++; $display("FAIL reset_mul_result: got %h want 0", mul_result); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    total++; if (hilo_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", hilo_rdata); end
  endtask

  task automatic test_multu();
    int n; bit d;
    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, d);
    total++; if (!d) begin bad++; $display("FAIL multu_done_timeout: got no done want done"); end
    total++; if (n !== 33) begin bad++; $display("FAIL multu_stall_cycles: got %0d want 33", n); end
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL multu_stall_at_done: got %b want 0", stallreq); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    step();
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_idle_after: got done=%b want 0", done); end
  endtask

  task automatic test_div();
    int n; bit d;
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, n, d);
    total++; if (!d || n !== 33) begin bad++; $display("FAIL div_timing: got done=%b stall=%0d want 1/33", d, n); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    run_op(OpDivu, 32'hFFFF_FFF9, 32'd2, n, d);
    total++; if (!d || n !== 33) begin bad++; $display("FAIL divu_timing: got done=%b stall=%0d want 1/33", d, n); end
    total++; if (lo !== 32'h7FFF_FFFC) begin bad++; $display("FAIL divu_lo: got %h want 7ffffffc", lo); end
    total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL divu_hi: got %h want 00000001", hi); end
  endtask

  task automatic test_div_zero();
    int n; bit d;
    run_op(OpDivu, 32'h0000_1234, 32'd0, n, d);
    total++; if (!d || n !== 33) begin bad++; $display("FAIL div0_timing: got done=%b stall=%0d want 1/33", d, n); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL div0_hi: got %h want 00001234", hi); end
  endtask

  task automatic test_mul_preserve();
    int n; bit d;
    step();
    op_valid = 1'b1; hilo_op = OpMthi; src_a = 32'h0000_AAAA;
    @(negedge clk);
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL mthi_stall: got %b want 0", stallreq); end
    step();
    hilo_op = OpMtlo; src_a = 32'h0000_5555;
    step();
    op_valid = 1'b0; hilo_op = '0;
    @(negedge clk);
    total++; if ({hi, lo} !== 64'h0000_AAAA_0000_5555) begin bad++; $display("FAIL mthi_mtlo: got %h want 0000aaaa00005555", {hi, lo}); end
    run_op(OpMul, 32'hFFFF_FFFD, 32'd5, n, d);
    total++; if (!d || n !== 33) begin bad++; $display("FAIL mul_timing: got done=%b stall=%0d want 1/33", d, n); end
    total++; if (mul_result !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mul_result: got %h want fffffff1", mul_result); end
    total++; if ({hi, lo} !== 64'h0000_AAAA_0000_5555) begin bad++; $display("FAIL mul_hilo_kept: got %h want 0000aaaa00005555", {hi, lo}); end
    step();
    op_valid = 1'b1; hilo_op = OpMfhi;
    @(negedge clk);
    total++; if (hilo_rdata !== 32'h0000_AAAA) begin bad++; $display("FAIL mfhi: got %h want 0000aaaa", hilo_rdata); end
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL mfhi_stall: got %b want 0", stallreq); end
    step();
    hilo_op = OpMflo;
    @(negedge clk);
    total++; if (hilo_rdata !== 32'h0000_5555) begin bad++; $display("FAIL mflo: got %h want 00005555", hilo_rdata); end
    step();
    op_valid = 1'b0; hilo_op = '0;
  endtask

  task automatic test_flush();
    int n; bit d;
    step();
    op_valid = 1'b1; hilo_op = OpDiv; src_a = 32'd100; src_b = 32'd7;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    @(negedge clk);
    total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL flush_stall_same_cycle: got %b want 1", stallreq); end
    step();
    flush = 1'b0; op_valid = 1'b0; hilo_op = '0;
    @(negedge clk);
    total++; if (stallreq !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle: got stall=%b done=%b want 0/0", stallreq, done); end
    repeat (30) step();
    @(negedge clk);
    total++; if ({hi, lo} !== 64'h0000_AAAA_0000_5555) begin bad++; $display("FAIL flush_hilo_kept: got %h want 0000aaaa00005555", {hi, lo}); end
    run_op(OpMultu, 32'd3, 32'd4, n, d);
    total++; if (!d || n !== 33) begin bad++; $display("FAIL flush_next_timing: got done=%b stall=%0d want 1/33", d, n); end
    total++; if ({hi, lo} !== 64'd12) begin bad++; $display("FAIL flush_next_multu: got %h want 000000000000000c", {hi, lo}); end
    step();
  endtask

  task automatic test_ex_stall();
    int n; bit d; int dn;
    ex_stall = 1'b1;
    run_op(OpMult, 32'd2, 32'd3, n, d);
    total++; if (!d || n !== 33) begin bad++; $display("FAIL exstall_timing: got done=%b stall=%0d want 1/33", d, n); end
    total++; if ({hi, lo} !== 64'd6) begin bad++; $display("FAIL exstall_hilo: got %h want 0000000000000006", {hi, lo}); end
    dn = 1;
    for (int i = 2; i <= 5; i++) begin
      step();
      if (i == 5) ex_stall = 1'b0;
      @(negedge clk);
      if (done) dn++;
    end
    step();
    @(negedge clk);
    if (done) dn++;
    total++; if (dn !== 5) begin bad++; $display("FAIL exstall_done_cycles: got %0d want 5", dn); end
    total++; if (stallreq !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL exstall_idle: got stall=%b done=%b want 0/0", stallreq, done); end
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL exstall_lo_final: got %h want 00000006", lo); end
  endtask

  task automatic test_flush_idle();
    step();
    op_valid = 1'b1; hilo_op = OpMtlo; src_a = 32'hDEAD_BEEF; flush = 1'b1;
    step();
    hilo_op = OpMultu; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL flush_idle_start: got stall=%b want 0", stallreq); end
    step();
    flush = 1'b0; op_valid = 1'b0; hilo_op = '0;
    @(negedge clk);
    total++; if (lo !== 32'd6 || done !== 1'b0) begin bad++; $display("FAIL flush_idle_mtlo: got lo=%h done=%b want 6/0", lo, done); end
  endtask

  task automatic test_reset_mid();
    step();
    op_valid = 1'b1; hilo_op = OpMultu; src_a = 32'd7; src_b = 32'd7;
    repeat (5) step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0; hilo_op = '0;
    @(negedge clk);
    total++; if ({hi, lo} !== 64'h0 || stallreq !== 1'b0) begin bad++; $display("FAIL rst_mid: got hilo=%h stall=%b want 0/0", {hi, lo}, stallreq); end
    total++; if (mul_result !== 32'h0) begin bad++; $display("FAIL rst_mid_mul_result: got %h want 0", mul_result); end
    repeat (40) step();
    @(negedge clk);
    total++; if (done !== 1'b0 || {hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_mid_no_commit: got done=%b hilo=%h want 0/0", done, {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_div();
    test_div_zero();
    test_mul_preserve();
    test_flush();
    test_ex_stall();
    test_flush_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
